imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage_if.sv | 46 ++++
 rtl/imm_decode_stage.sv | 133 +++++++++++++
 tb/tb_imm_decode_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage_if
// Description : Handshake and decoded-field bundle of the immediate decode
//               stage. The slave side belongs to the stage; the master side
//               belongs to the fetch/execute neighbours (or a bench).
// Revision    : 1.0  initial release
// ============================================================================
interface imm_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  // Upstream side
  logic                inValid;
  logic                inReady;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pcIn;
  logic                flush;
  // Downstream side
  logic                outValid;
  logic                outReady;
  logic [PC_WIDTH-1:0] pcOut;
  logic [5:0]          opcode;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [4:0]          shamt;
  logic [5:0]          funct;
  logic [15:0]         imm;
  logic                signExtend;
  logic                isBranch;
  logic                isDelaySlot;
  logic                illegal;

  modport slave (
    input  inValid, instr, pcIn, flush, outReady,
    output inReady, outValid, pcOut, opcode, rs, rt, rd, shamt, funct,
           imm, signExtend, isBranch, isDelaySlot, illegal
  );

  modport master (
    output inValid, instr, pcIn, flush, outReady,
    input  inReady, outValid, pcOut, opcode, rs, rt, rd, shamt, funct,
           imm, signExtend, isBranch, isDelaySlot, illegal
  );
endinterface : imm_decode_stage_if
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : One-deep MIPS decode register. Splits the instruction word
//               into fields, classifies the opcode (extension mode, branch,
//               illegal) and tags instructions sitting in a branch delay slot.
// Revision    : 1.0  initial release
// ============================================================================
module imm_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  imm_decode_stage_if.slave bus
);

  // Delay-slot tracker: SLOT means the previously accepted instruction was a
  // branch, so the next accepted one executes in its delay slot.
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_SLOT   = 1'b1
  } state_e;

  state_e              state_q, state_d;

  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         instr_q;
  logic                sext_q;
  logic                branch_q;
  logic                slot_q;
  logic                illegal_q;

  logic                w_accept;
  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic                w_sext;
  logic                w_branch;
  logic                w_illegal;

  assign bus.inReady = !valid_q || bus.outReady;
  assign w_accept    = bus.inValid && bus.inReady && !bus.flush;
  assign w_op        = bus.instr[31:26];
  assign w_funct     = bus.instr[5:0];

  // Opcode classification of the incoming word.
  always_comb begin
    w_sext    = 1'b1;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      6'h00: begin
        // SPECIAL: only JR/JALR redirect the PC.
        w_sext   = 1'b0;
        w_branch = (w_funct == 6'h08) || (w_funct == 6'h09);
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: w_branch = 1'b1;
      6'h02, 6'h03: begin
        // J/JAL carry a target index, not a signed offset.
        w_sext   = 1'b0;
        w_branch = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: w_sext = 1'b1;
      // Logical immediates and LUI are zero-extended.
      6'h0C, 6'h0D, 6'h0E, 6'h0F: w_sext = 1'b0;
      default: begin
        w_illegal = 1'b1;
        w_sext    = 1'b0;
      end
    endcase
  end

  // Delay-slot next state: flush clears it, stalls keep it.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_NORMAL;
    end else if (w_accept) begin
      state_d = w_branch ? ST_SLOT : ST_NORMAL;
    end
  end

  // Delay-slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: load on accept, hold under stall, drop on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      sext_q    <= 1'b0;
      branch_q  <= 1'b0;
      slot_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (w_accept) begin
      valid_q   <= 1'b1;
      pc_q      <= bus.pcIn;
      instr_q   <= bus.instr;
      sext_q    <= w_sext;
      branch_q  <= w_branch;
      slot_q    <= (state_q == ST_SLOT);
      illegal_q <= w_illegal;
    end else if (bus.outReady) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.outValid    = valid_q;
  assign bus.pcOut       = pc_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.shamt       = instr_q[10:6];
  assign bus.funct       = instr_q[5:0];
  assign bus.imm         = instr_q[15:0];
  assign bus.signExtend  = sext_q;
  assign bus.isBranch    = branch_q;
  assign bus.isDelaySlot = slot_q;
  assign bus.illegal     = illegal_q;

endmodule : imm_decode_stage
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Scoreboard bench for imm_decode_stage. A predictor pushes the
//               expected decode of every accepted instruction; a monitor
//               compares whatever the stage presents against the queue head.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imm_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        sext;
    logic        br;
    logic        ds;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  exp_t sb[$];
  logic m_valid;   // model: an instruction is held for downstream
  logic m_slot;    // model: last accepted instruction was a branch

  imm_decode_stage_if #(.PC_WIDTH(32)) bus ();

  imm_decode_stage #(.PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the opcode tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic in_slot);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        supported;
    logic        zext;
    op        = ins[31:26];
    fn        = ins[5:0];
    supported = (op <= 6'h0F) ||
                (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B});
    zext      = op inside {6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    e.pc      = pc;
    e.instr   = ins;
    e.ill     = !supported;
    e.sext    = supported && !zext;
    e.br      = supported && ((op >= 6'h01 && op <= 6'h07) ||
                              (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)));
    e.ds      = in_slot;
    return e;
  endfunction

  // Predictor: evaluates the handshake on each rising edge.
  initial begin : p_predict
    logic rdy;
    logic acc;
    exp_t e;
    m_valid = 1'b0;
    m_slot  = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        m_valid = 1'b0;
        m_slot  = 1'b0;
      end else begin
        rdy = !m_valid || bus.outReady;
        acc = bus.inValid && rdy && !bus.flush;
        if (bus.flush) begin
          if (m_valid && !bus.outReady && sb.size() > 0) void'(sb.pop_back());
          m_valid = 1'b0;
          m_slot  = 1'b0;
        end else if (acc) begin
          e = ref_decode(bus.instr, bus.pcIn, m_slot);
          sb.push_back(e);
          m_valid = 1'b1;
          m_slot  = e.br;
        end else if (bus.outReady) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares the presented instruction every cycle it is shown.
  initial begin : p_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("inReady", {63'd0, bus.inReady}, {63'd0, (!m_valid || bus.outReady)});
        chk("outValid", {63'd0, bus.outValid}, {63'd0, m_valid});
        if (bus.outValid) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb[0];
            chk("pcOut", {32'd0, bus.pcOut}, {32'd0, e.pc});
            chk("fields", {32'd0, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct},
                {32'd0, e.instr});
            chk("imm", {48'd0, bus.imm}, {48'd0, e.instr[15:0]});
            chk("flags", {60'd0, bus.signExtend, bus.isBranch, bus.isDelaySlot, bus.illegal},
                {60'd0, e.sext, e.br, e.ds, e.ill});
            if (bus.outReady) void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    bus.inValid  = v;
    bus.instr    = ins;
    bus.pcIn     = pc;
    bus.flush    = fl;
    bus.outReady = ordy;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_outValid", {63'd0, bus.outValid}, 64'd0);
    chk("rst_inReady", {63'd0, bus.inReady}, 64'd1);
    chk("rst_pcOut", {32'd0, bus.pcOut}, 64'd0);
    chk("rst_fields", {32'd0, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
                       bus.imm, bus.signExtend, bus.isBranch, bus.isDelaySlot, bus.illegal},
        64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [24] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                              6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    logic [31:0] r;
    logic [5:0]  op;
    int          sel;
    r   = $urandom();
    sel = int'($urandom_range(0, 9));
    if (sel <= 6)      op = ops[$urandom_range(0, 23)];
    else if (sel == 7) op = 6'h00;
    else if (sel == 8) op = 6'($urandom_range(0, 63));
    else               op = 6'($urandom_range(1, 7));
    r[31:26] = op;
    if (sel == 7) r[5:0] = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h09;
    return r;
  endfunction

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_driver
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.inValid  = 1'b0;
    bus.instr    = '0;
    bus.pcIn     = '0;
    bus.flush    = 1'b0;
    bus.outReady = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // ADDI, ORI and an illegal opcode back to back
    step(1'b1, 32'h2008FFFF, 32'h100, 1'b0, 1'b1);
    step(1'b1, 32'h3508FFFF, 32'h104, 1'b0, 1'b1);
    step(1'b1, 32'hFC000000, 32'h108, 1'b0, 1'b1);
    // BEQ, ADDI in its slot, then a plain ADD
    step(1'b1, 32'h11090004, 32'h10C, 1'b0, 1'b1);
    step(1'b1, 32'h21080001, 32'h110, 1'b0, 1'b1);
    step(1'b1, 32'h01095020, 32'h114, 1'b0, 1'b1);
    // Three-cycle downstream stall with a new word waiting
    step(1'b1, 32'h8D2A0010, 32'h118, 1'b0, 1'b1);
    repeat (3) step(1'b1, 32'hAD2A0014, 32'h11C, 1'b0, 1'b0);
    step(1'b1, 32'hAD2A0014, 32'h11C, 1'b0, 1'b1);
    // Branch followed by flush with a word offered
    step(1'b1, 32'h11090004, 32'h200, 1'b0, 1'b1);
    step(1'b1, 32'h21080002, 32'h204, 1'b1, 1'b1);
    step(1'b1, 32'h21080003, 32'h208, 1'b0, 1'b1);
    // Branch held under stall, then asynchronous reset between edges
    step(1'b1, 32'h0800_0040, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b1, 32'h21080004, 32'h304, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Random traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_imm_decode_stage
`default_nettype wire
